disp_scheduler: RTL and testbench
=================================

// Module: disp_scheduler
// PURPOSE
//  Time-shares the 8-digit 7-segment display between N_REQ requesters.
//  - Each requester offers a 32-bit hex word (8 nibbles).
//  - A round-robin arbiter grants one requester and latches its word.
//  - The word is shown for HOLD_CYCLES clocks, then arbitration repeats.
//  - Outputs disp_num/disp_on feed the 7-seg driver's in_num/turn_on.
// PARAMETERS
//  N_REQ        4            number of requesters (2..8)
//  HOLD_CYCLES  100_000_000  display hold time per grant, clk cycles (>=2)
//  CNT_W        $clog2(HOLD_CYCLES)  hold-timer width (derived, do not override)
// PORTS
//  clk       in   1         system clock, all state on posedge
//  reset     in   1         asynchronous, active-low reset
//  req       in   N_REQ     request per source, level, held until grant seen
//  req_data  in   32*N_REQ  word of source i at [32*i+31:32*i]
//  grant     out  N_REQ     one-hot, 1-cycle pulse: word of that source latched
//  disp_num  out  32        word to display
//  disp_on   out  1         display enable
//  owner     out  3         index of current/last owner
//  busy      out  1         1 while in SHOW
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, disp_num=0, disp_on=0, grant=0,
//    owner=0, busy=0, timer=0, rr_last=N_REQ-1 (source 0 wins first).
//  - FSM IDLE: disp_on=0; if |req in cycle k -> at edge: latch winner word,
//    grant[w]=1 and disp_on=1 in cycle k+1, timer=HOLD_CYCLES-1, go SHOW.
//  - FSM SHOW: busy=1, disp_on=1; timer decrements each cycle; req ignored.
//  - Timer==0 in SHOW:
//    - if |req: re-arbitrate same cycle; back-to-back grant, stay SHOW.
//    - else: go IDLE; disp_num keeps its value, disp_on=0.
//  - Round-robin: search starts at rr_last+1 mod N_REQ; rr_last=winner on grant.
//    A sole requester is re-granted on every expiry.
//  - Request and data are sampled only in the arbitration cycle. A req dropped
//    before that cycle is never granted. No grant without req.
//  - Total on-time per grant is exactly HOLD_CYCLES cycles.
//  - grant high 1 cycle only. owner updates with grant, holds otherwise.
//  - Async reset mid-SHOW: immediate return to reset values, no grant pulse.
// CONFIGURATION
//  DISP_SCHED_PREEMPT_EN defined:
//    - source 0 is urgent: req[0] in SHOW with owner!=0 preempts at once.
//    - grant[0] next cycle, timer reloaded; rr_last unchanged by the preemption.
//  Not defined:
//    - pure round-robin, no preemption; req[0] waits like any source.
// STRUCTURE
//  - Package disp_pkg:
//    - typedef enum logic {IDLE, SHOW} sched_state_t
//    - localparam DISP_W=32
//    - function rr_pick(req, last) returning winner index + valid
//  - Sub-module rr_arbiter (#N): combinational req/last -> one-hot + index.
//  - Top: FSM, hold timer, data latch.
// TESTING (bench uses N_REQ=4, HOLD_CYCLES=4)
//  - Reset -> disp_on=0, disp_num=0, grant=0, busy=0; release with no req ->
//    stays IDLE.
//  - req=0100, data2=32'hCAFE_0002 -> grant=0100 next cycle, disp_num=CAFE_0002,
//    disp_on=1 for exactly 4 cycles, then IDLE, disp_on=0.
//  - req=1111 held continuously -> grants 0001,0010,0100,1000,0001 spaced
//    4 cycles, no idle gap.
//  - Only req[1] held -> grant[1] every 4 cycles, owner=1 throughout.
//  - reset driven low in 2nd SHOW cycle -> all outputs 0 immediately;
//    after release + req=0001 -> source 0 granted first.
//  - Preempt macro on: owner=2, req[0] asserted mid-hold -> grant=0001 next
//    cycle, 4 full cycles shown. Macro off: same stimulus -> grant[0] only
//    after source 2's hold expires.

Source files
------------

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types, widths and round-robin pick function for the display scheduler
package disp_pkg;

    typedef enum logic {IDLE, SHOW} sched_state_t;

    localparam int DISP_W  = 32;
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Search begins one past the last winner and wraps within the first n sources.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [IDX_W-1:0]   last,
                                         input int                 n);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            if (i <= n) begin
                j = int'(last) + i;
                if (j >= n) begin
                    j = j - n;
                end
                if (!r.valid && req[j[IDX_W-1:0]]) begin
                    r.valid = 1'b1;
                    r.idx   = j[IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter: requests + last winner -> one-hot grant and index
module rr_arbiter
    import disp_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [MAX_REQ-1:0] w_req;
    rr_pick_t           w_pick;

    always_comb begin
        w_req        = '0;
        w_req[N-1:0] = i_req;
        w_pick       = rr_pick(w_req, i_last, N);
        o_valid      = w_pick.valid;
        o_idx        = w_pick.idx;
        o_gnt        = '0;
        for (int i = 0; i < N; i++) begin
            o_gnt[i] = w_pick.valid && (w_pick.idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/disp_scheduler.sv
// rtl/disp_scheduler.sv - time-shares the 7-seg display between requesters; DISP_SCHED_PREEMPT_EN makes source 0 urgent
module disp_scheduler
    import disp_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int CNT_W       = $clog2(HOLD_CYCLES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [DISP_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic [DISP_W-1:0]       disp_num,
    output logic                    disp_on,
    output logic [IDX_W-1:0]        owner,
    output logic                    busy
);

    localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(HOLD_CYCLES - 1);

    sched_state_t      r_state;
    logic [CNT_W-1:0]  r_timer;
    logic [N_REQ-1:0]  r_grant;
    logic [DISP_W-1:0] r_disp_num;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  r_rr_last;

    sched_state_t      w_state_nxt;
    logic [CNT_W-1:0]  w_timer_nxt;
    logic              w_load;
    logic              w_rr_upd;
    logic [IDX_W-1:0]  w_load_idx;
    logic [N_REQ-1:0]  w_load_oh;
    logic [DISP_W-1:0] w_load_data;
    logic              w_preempt;

    logic [N_REQ-1:0]  w_arb_oh;
    logic [IDX_W-1:0]  w_arb_idx;
    logic              w_arb_valid;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .i_req   (req),
        .i_last  (r_rr_last),
        .o_gnt   (w_arb_oh),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

`ifdef DISP_SCHED_PREEMPT_EN
    assign w_preempt = (r_state == SHOW) && req[0] && (r_owner != '0);
`else
    assign w_preempt = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_load      = 1'b0;
        w_rr_upd    = 1'b0;
        w_load_idx  = w_arb_idx;
        w_load_oh   = w_arb_oh;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_load      = 1'b1;
                    w_rr_upd    = 1'b1;
                    w_state_nxt = SHOW;
                end
            end
            SHOW: begin
                // A preemption leaves rr_last alone so the rotation resumes where it was.
                if (w_preempt) begin
                    w_load     = 1'b1;
                    w_load_idx = '0;
                    w_load_oh  = N_REQ'(1);
                end else if (r_timer == '0) begin
                    if (w_arb_valid) begin
                        w_load   = 1'b1;
                        w_rr_upd = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
        endcase
        if (w_load) begin
            w_timer_nxt = TIMER_LOAD;
        end
    end

    always_comb begin
        w_load_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_load_idx == IDX_W'(i)) begin
                w_load_data = req_data[i*DISP_W +: DISP_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_grant    <= '0;
            r_disp_num <= '0;
            r_owner    <= '0;
            r_rr_last  <= IDX_W'(N_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_grant <= w_load ? w_load_oh : '0;
            if (w_load) begin
                r_disp_num <= w_load_data;
                r_owner    <= w_load_idx;
            end
            if (w_rr_upd) begin
                r_rr_last <= w_load_idx;
            end
        end
    end

    assign grant    = r_grant;
    assign disp_num = r_disp_num;
    assign owner    = r_owner;
    assign busy     = (r_state == SHOW);
    assign disp_on  = (r_state == SHOW);

endmodule

// File: tb/tb_disp_scheduler.sv
// tb/tb_disp_scheduler.sv - table-driven bench for disp_scheduler (N_REQ=4, HOLD_CYCLES=4)
module tb_disp_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   grant;
    logic [31:0]  disp_num;
    logic         disp_on;
    logic [2:0]   owner;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  grant;
        logic        on;
        logic [2:0]  owner;
        logic [31:0] num;
    } vec_t;

    vec_t vecs[$];

    disp_scheduler #(.N_REQ(4), .HOLD_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .disp_num (disp_num),
        .disp_on  (disp_on),
        .owner    (owner),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dword(input int k);
        return 32'hCAFE_0000 | 32'(k);
    endfunction

    function automatic logic [3:0] oh(input int k);
        return 4'(1 << k);
    endfunction

    function automatic void add(input logic rst, input logic [3:0] r, input logic [3:0] g,
                                input logic on, input int own, input logic [31:0] num);
        vec_t v;
        v.rst = rst; v.req = r; v.grant = g; v.on = on; v.owner = 3'(own); v.num = num;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " grant"},    32'(grant), 32'h0);
        check({tag, " disp_on"},  32'(disp_on), 32'h0);
        check({tag, " disp_num"}, disp_num, 32'h0);
        check({tag, " owner"},    32'(owner), 32'h0);
        check({tag, " busy"},     32'(busy), 32'h0);
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        reset = 1'b0;
        #2;
        check_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        req   = 4'b0000;
        for (int k = 0; k < 4; k++) req_data[32*k +: 32] = dword(k);

        // Single request from source 2, shown for 4 cycles then idle with word kept
        add(1, 4'b0000, 4'b0000, 0, 0, 32'h0);
        add(0, 4'b0000, 4'b0000, 0, 0, 32'h0);
        add(0, 4'b0100, 4'b0100, 1, 2, dword(2));
        for (int j = 0; j < 3; j++) add(0, 4'b0000, 4'b0000, 1, 2, dword(2));
        add(0, 4'b0000, 4'b0000, 0, 2, dword(2));

        // All sources requesting: rotation 0,1,2,3,0 with no idle gap
        for (int j = 0; j < 17; j++)
            add(j == 0, 4'b1111, (j % 4 == 0) ? oh((j / 4) % 4) : 4'b0000, 1, (j / 4) % 4, dword((j / 4) % 4));

        // Sole requester re-granted on every expiry, then idles when it drops
        for (int j = 0; j < 12; j++)
            add(j == 0, 4'b0010, (j % 4 == 0) ? 4'b0010 : 4'b0000, 1, 1, dword(1));
        add(0, 4'b0000, 4'b0000, 0, 1, dword(1));

        // Source 0 requests while source 2 holds the display
        add(1, 4'b0100, 4'b0100, 1, 2, dword(2));
        add(0, 4'b0000, 4'b0000, 1, 2, dword(2));
`ifdef DISP_SCHED_PREEMPT_EN
        add(0, 4'b0001, 4'b0001, 1, 0, dword(0));
        for (int j = 0; j < 3; j++) add(0, 4'b0000, 4'b0000, 1, 0, dword(0));
        add(0, 4'b0000, 4'b0000, 0, 0, dword(0));
`else
        add(0, 4'b0001, 4'b0000, 1, 2, dword(2));
        add(0, 4'b0001, 4'b0000, 1, 2, dword(2));
        add(0, 4'b0001, 4'b0001, 1, 0, dword(0));
        for (int j = 0; j < 3; j++) add(0, 4'b0000, 4'b0000, 1, 0, dword(0));
        add(0, 4'b0000, 4'b0000, 0, 0, dword(0));
`endif

        #2;
        check_zero("por");
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            req = vecs[i].req;
            @(posedge clk);
            #1;
            check($sformatf("v%0d grant", i),    32'(grant),   32'(vecs[i].grant));
            check($sformatf("v%0d disp_on", i),  32'(disp_on), 32'(vecs[i].on));
            check($sformatf("v%0d busy", i),     32'(busy),    32'(vecs[i].on));
            check($sformatf("v%0d owner", i),    32'(owner),   32'(vecs[i].owner));
            check($sformatf("v%0d disp_num", i), disp_num,     vecs[i].num);
        end

        // Asynchronous reset in the second SHOW cycle, then rr_last must restart at source 0
        do_reset();
        req = 4'b0100;
        @(posedge clk);
        #1;
        check("mid grant2", 32'(grant), 32'h4);
        req = 4'b0000;
        @(posedge clk);
        #1;
        check("mid busy", 32'(busy), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check_zero("mid async");
        @(posedge clk);
        #1;
        check_zero("mid held");
        reset = 1'b1;
        req   = 4'b1001;
        @(posedge clk);
        #1;
        check("post grant", 32'(grant), 32'h1);
        check("post owner", 32'(owner), 32'h0);
        check("post num",   disp_num,   dword(0));
        req = 4'b0000;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
